bank_group_ctrl: RTL and testbench

- Parametrised successor to the DRAM-emulator bank group.
- Tracks an independent state machine and open row per bank, and enforces tRCD, tRP, tRAS and tRFC with per-bank counters.
- Runs one read/write burst engine per group, generating beat-by-beat column addresses and burst strobes for the storage array.
- Sits between the rank command decoder and the bank storage arrays; a halt input freezes all progress for emulation stalls.

---
 rtl/bank_group_ctrl.sv | 178 +++++++++++++++++
 tb/tb_bank_group_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_group_ctrl.sv
`default_nettype none
// bank_group_ctrl: per-bank ACT/PRE/REF timing state machines plus one RD/WR burst engine.
// Revision: 1.0
module bank_group_ctrl #(
  parameter int BANKSPERGROUP = 4,
  parameter int ADDRWIDTH     = 17,
  parameter int COLS          = 1024,
  parameter int BL            = 8,
  parameter int TRCD          = 4,
  parameter int TRP           = 4,
  parameter int TRAS          = 10,
  parameter int TRFC          = 20
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               halt,
  input  logic [2:0]                         cmd,
  input  logic [$clog2(BANKSPERGROUP)-1:0]   ba,
  input  logic [ADDRWIDTH-1:0]               row,
  input  logic [$clog2(COLS)-1:0]            column,
  output logic                               cmd_ack,
  output logic                               cmd_err,
  output logic [3*BANKSPERGROUP-1:0]         bank_state,
  output logic [ADDRWIDTH*BANKSPERGROUP-1:0] open_row,
  output logic                               burst_valid,
  output logic                               burst_wr,
  output logic [$clog2(BANKSPERGROUP)-1:0]   burst_bank,
  output logic [$clog2(COLS)-1:0]            burst_col,
  output logic                               burst_last
);
  localparam int BW   = $clog2(BANKSPERGROUP);
  localparam int CW   = $clog2(COLS);
  localparam int T1   = (TRCD > TRP) ? TRCD : TRP;
  localparam int T2   = (TRAS > TRFC) ? TRAS : TRFC;
  localparam int TMAX = (T1 > T2) ? T1 : T2;
  localparam int CNTW = $clog2(TMAX + 1);
  localparam int IW   = (BL > 1) ? $clog2(BL) : 1;

  localparam logic [CNTW-1:0] TRCD_C  = CNTW'(TRCD);
  localparam logic [CNTW-1:0] TRP_C   = CNTW'(TRP);
  localparam logic [CNTW-1:0] TRAS_C  = CNTW'(TRAS);
  localparam logic [CNTW-1:0] TRFC_C  = CNTW'(TRFC);
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [IW-1:0]   LAST_BEAT = IW'(BL - 1);
  localparam logic [CW-1:0]   BEAT_MASK = CW'(BL - 1);

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_PRE  = 3'd4;
  localparam logic [2:0] CMD_PREA = 3'd5;
  localparam logic [2:0] CMD_REF  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_ACTIVATING  = 3'd1,
    S_ACTIVE      = 3'd2,
    S_PRECHARGING = 3'd3,
    S_REFRESHING  = 3'd4
  } bank_state_t;

  bank_state_t              state   [BANKSPERGROUP];
  bank_state_t              eff     [BANKSPERGROUP];
  logic [CNTW-1:0]          tcnt    [BANKSPERGROUP];
  logic [CNTW-1:0]          ras_cnt [BANKSPERGROUP];
  logic [ADDRWIDTH-1:0]     row_q   [BANKSPERGROUP];
  logic [BANKSPERGROUP-1:0] pre_ok;
  logic [BANKSPERGROUP-1:0] idle_v;

  logic          busy;
  logic [IW-1:0] beat;
  logic [CW-1:0] base_col;
  logic          legal;

  // eff is the state a command sampled at this edge sees: a timed state whose
  // counter has reached its terminal value already counts as finished.
  always_comb begin
    for (int b = 0; b < BANKSPERGROUP; b++) begin
      eff[b] = state[b];
      case (state[b])
        S_ACTIVATING:  if (tcnt[b] >= TRCD_C) eff[b] = S_ACTIVE;
        S_PRECHARGING: if (tcnt[b] >= TRP_C)  eff[b] = S_IDLE;
        S_REFRESHING:  if (tcnt[b] >= TRFC_C) eff[b] = S_IDLE;
        default: ;
      endcase
      idle_v[b] = (eff[b] == S_IDLE);
      pre_ok[b] = (eff[b] == S_IDLE) ||
                  ((eff[b] == S_ACTIVE) && (ras_cnt[b] >= TRAS_C) &&
                   !(busy && (burst_bank == BW'(b))));
    end
  end

  always_comb begin
    legal = 1'b0;
    case (cmd)
      CMD_ACT:        legal = (eff[ba] == S_IDLE);
      CMD_RD, CMD_WR: legal = (eff[ba] == S_ACTIVE) && (!busy || (beat == LAST_BEAT));
      CMD_PRE:        legal = pre_ok[ba];
      CMD_PREA:       legal = &pre_ok;
      CMD_REF:        legal = &idle_v;
      default:        legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < BANKSPERGROUP; b++) begin
        state[b]   <= S_IDLE;
        tcnt[b]    <= '0;
        ras_cnt[b] <= '0;
        row_q[b]   <= '0;
      end
      cmd_ack    <= 1'b0;
      cmd_err    <= 1'b0;
      busy       <= 1'b0;
      beat       <= '0;
      burst_wr   <= 1'b0;
      burst_bank <= '0;
      base_col   <= '0;
    end else if (halt) begin
      cmd_ack <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      cmd_ack <= (cmd != CMD_NOP) && legal;
      cmd_err <= (cmd != CMD_NOP) && !legal;
      for (int b = 0; b < BANKSPERGROUP; b++) begin
        state[b] <= eff[b];
        if ((eff[b] == state[b]) && (state[b] != S_IDLE) && (state[b] != S_ACTIVE))
          tcnt[b] <= tcnt[b] + CNT_ONE;
        if (ras_cnt[b] < TRAS_C)
          ras_cnt[b] <= ras_cnt[b] + CNT_ONE;
        if (legal) begin
          if ((cmd == CMD_ACT) && (ba == BW'(b))) begin
            state[b]   <= S_ACTIVATING;
            tcnt[b]    <= CNT_ONE;
            ras_cnt[b] <= CNT_ONE;
            row_q[b]   <= row;
          end
          // PRE/PREA on an idle bank is an acknowledged no-op
          if ((eff[b] == S_ACTIVE) &&
              ((cmd == CMD_PREA) || ((cmd == CMD_PRE) && (ba == BW'(b))))) begin
            state[b] <= S_PRECHARGING;
            tcnt[b]  <= CNT_ONE;
          end
          if (cmd == CMD_REF) begin
            state[b] <= S_REFRESHING;
            tcnt[b]  <= CNT_ONE;
          end
        end
      end
      if (busy) begin
        if (beat == LAST_BEAT) busy <= 1'b0;
        else                   beat <= beat + IW'(1);
      end
      if (legal && ((cmd == CMD_RD) || (cmd == CMD_WR))) begin
        busy       <= 1'b1;
        beat       <= '0;
        burst_wr   <= (cmd == CMD_WR);
        burst_bank <= ba;
        base_col   <= column;
      end
    end
  end

  assign burst_valid = busy & ~halt;
  assign burst_last  = busy & ~halt & (beat == LAST_BEAT);
  assign burst_col   = (base_col & ~BEAT_MASK) | ((base_col + CW'(beat)) & BEAT_MASK);

  generate
    for (genvar g = 0; g < BANKSPERGROUP; g++) begin : g_bank_out
      assign bank_state[3*g +: 3]                = state[g];
      assign open_row[ADDRWIDTH*g +: ADDRWIDTH] = row_q[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bank_group_ctrl.sv
`default_nettype none
// tb_bank_group_ctrl: scoreboard bench; a tick-based reference model predicts
// command responses, bank states, open rows and burst beats.
module tb_bank_group_ctrl;
  localparam int N     = 4;
  localparam int AW    = 17;
  localparam int NCOLS = 1024;
  localparam int BLEN  = 8;
  localparam int TRCD  = 4;
  localparam int TRP   = 4;
  localparam int TRAS  = 10;
  localparam int TRFC  = 20;
  localparam int BW    = 2;
  localparam int CW    = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              halt;
  logic [2:0]        cmd;
  logic [BW-1:0]     ba;
  logic [AW-1:0]     row;
  logic [CW-1:0]     column;
  logic              cmd_ack;
  logic              cmd_err;
  logic [3*N-1:0]    bank_state;
  logic [AW*N-1:0]   open_row;
  logic              burst_valid;
  logic              burst_wr;
  logic [BW-1:0]     burst_bank;
  logic [CW-1:0]     burst_col;
  logic              burst_last;

  bank_group_ctrl #(
    .BANKSPERGROUP(N), .ADDRWIDTH(AW), .COLS(NCOLS), .BL(BLEN),
    .TRCD(TRCD), .TRP(TRP), .TRAS(TRAS), .TRFC(TRFC)
  ) dut (
    .clk(clk), .reset(reset), .halt(halt), .cmd(cmd), .ba(ba), .row(row),
    .column(column), .cmd_ack(cmd_ack), .cmd_err(cmd_err),
    .bank_state(bank_state), .open_row(open_row), .burst_valid(burst_valid),
    .burst_wr(burst_wr), .burst_bank(burst_bank), .burst_col(burst_col),
    .burst_last(burst_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wr;
    logic [BW-1:0] bank;
    logic [CW-1:0] col;
    logic          last;
  } beat_t;

  bit    resp_q[$];
  beat_t beat_q[$];

  // Model: base state and entry tick per bank; tick counts non-halted edges.
  int            mst  [N];
  int            ment [N];
  int            mact [N];
  logic [AW-1:0] mrow [N];
  int            tick;
  int            burst_left;
  int            mbank;
  int            vectors;
  int            miscompares;

  function automatic int eff(int b, int t);
    case (mst[b])
      1:       return (t - ment[b] >= TRCD) ? 2 : 1;
      3:       return (t - ment[b] >= TRP)  ? 0 : 3;
      4:       return (t - ment[b] >= TRFC) ? 0 : 4;
      default: return mst[b];
    endcase
  endfunction

  function automatic bit pre_ok(int b, int e, int t, bit busy);
    return (e == 0) || ((e == 2) && (t - mact[b] >= TRAS) && !(busy && mbank == b));
  endfunction

  function automatic void model_reset();
    for (int b = 0; b < N; b++) begin
      mst[b] = 0; ment[b] = 0; mact[b] = 0; mrow[b] = '0;
    end
    tick = 0; burst_left = 0; mbank = 0;
    resp_q.delete();
    beat_q.delete();
  endfunction

  function automatic void model_step();
    int    t, b0, lo, basecol;
    int    e [N];
    bit    busy, legal;
    beat_t bt;
    if (halt) return;
    t = tick + 1;
    busy = burst_left > 0;
    b0 = int'(ba);
    for (int b = 0; b < N; b++) e[b] = eff(b, t);
    legal = 1'b0;
    case (cmd)
      3'd1: legal = (e[b0] == 0);
      3'd2, 3'd3: legal = (e[b0] == 2) && (burst_left <= 1);
      3'd4: legal = pre_ok(b0, e[b0], t, busy);
      3'd5: begin
        legal = 1'b1;
        for (int b = 0; b < N; b++) if (!pre_ok(b, e[b], t, busy)) legal = 1'b0;
      end
      3'd6: begin
        legal = 1'b1;
        for (int b = 0; b < N; b++) if (e[b] != 0) legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    for (int b = 0; b < N; b++) mst[b] = e[b];
    if (legal) begin
      case (cmd)
        3'd1: begin mst[b0] = 1; ment[b0] = t; mact[b0] = t; mrow[b0] = row; end
        3'd4: if (e[b0] == 2) begin mst[b0] = 3; ment[b0] = t; end
        3'd5: for (int b = 0; b < N; b++) if (e[b] == 2) begin mst[b] = 3; ment[b] = t; end
        3'd6: for (int b = 0; b < N; b++) begin mst[b] = 4; ment[b] = t; end
        default: ;
      endcase
    end
    if (burst_left > 0) burst_left--;
    if (legal && (cmd == 3'd2 || cmd == 3'd3)) begin
      lo = int'(column) % BLEN;
      basecol = int'(column) - lo;
      for (int k = 0; k < BLEN; k++) begin
        bt.wr   = (cmd == 3'd3);
        bt.bank = ba;
        bt.col  = CW'(basecol + (lo + k) % BLEN);
        bt.last = (k == BLEN - 1);
        beat_q.push_back(bt);
      end
      burst_left = BLEN;
      mbank = b0;
    end
    if (cmd != 3'd0) resp_q.push_back(legal);
    tick = t;
  endfunction

  always @(negedge clk) begin : monitor
    logic [3*N-1:0]  es;
    logic [AW*N-1:0] er;
    beat_t           eb;
    bit              er_ack;
    for (int b = 0; b < N; b++) begin
      es[3*b +: 3]   = 3'(eff(b, tick));
      er[AW*b +: AW] = mrow[b];
    end
    vectors++;
    if (bank_state !== es || open_row !== er) begin
      miscompares++;
      $display("FAIL bank_state/open_row: got %h / %h, expected %h / %h", bank_state, open_row, es, er);
    end
    if (cmd_ack && cmd_err) begin
      vectors++; miscompares++;
      $display("FAIL ack_err_both: got ack=1 err=1, expected at most one");
    end else if (cmd_ack || cmd_err) begin
      vectors++;
      if (resp_q.size() == 0) begin
        miscompares++;
        $display("FAIL response: got ack=%b err=%b, expected no response", cmd_ack, cmd_err);
      end else begin
        er_ack = resp_q.pop_front();
        if (cmd_ack != er_ack) begin
          miscompares++;
          $display("FAIL response: got ack=%b err=%b, expected ack=%b", cmd_ack, cmd_err, er_ack);
        end
      end
    end else if (resp_q.size() > 0) begin
      vectors++; miscompares++;
      er_ack = resp_q.pop_front();
      $display("FAIL response: got none, expected ack=%b", er_ack);
    end
    if (halt) begin
      vectors++;
      if (burst_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL halt_valid: got burst_valid=%b, expected 0", burst_valid);
      end
    end else if (burst_valid) begin
      vectors++;
      if (beat_q.size() == 0) begin
        miscompares++;
        $display("FAIL beat: got unexpected beat col=%0d", burst_col);
      end else begin
        eb = beat_q.pop_front();
        if ({burst_wr, burst_bank, burst_col, burst_last} !== eb) begin
          miscompares++;
          $display("FAIL beat: got wr=%b bank=%0d col=%0d last=%b, expected wr=%b bank=%0d col=%0d last=%b",
                   burst_wr, burst_bank, burst_col, burst_last, eb.wr, eb.bank, eb.col, eb.last);
        end
      end
    end else if (beat_q.size() > 0) begin
      vectors++; miscompares++;
      eb = beat_q.pop_front();
      $display("FAIL beat: got no beat, expected col=%0d", eb.col);
    end
  end

  task automatic step(input int c, input int b, input int r, input int co, input bit h);
    cmd = 3'(c); ba = BW'(b); row = AW'(r); column = CW'(co); halt = h;
    @(posedge clk);
    if (!reset) model_step();
    #1;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1'b0);
  endtask

  task automatic check_cleared(input string tag);
    vectors++;
    if ({cmd_ack, cmd_err, bank_state, open_row, burst_valid, burst_wr,
         burst_bank, burst_col, burst_last} !== '0) begin
      miscompares++;
      $display("FAIL %s: got ack=%b err=%b state=%h row=%h valid=%b wr=%b bank=%0d col=%0d last=%b, expected all 0",
               tag, cmd_ack, cmd_err, bank_state, open_row, burst_valid, burst_wr,
               burst_bank, burst_col, burst_last);
    end
  endtask

  initial begin
    int p, c;
    vectors = 0; miscompares = 0;
    reset = 1'b1; halt = 1'b0; cmd = '0; ba = '0; row = '0; column = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset_state");
    reset = 1'b0;

    // ACT, early RD, RD after tRCD, back-to-back WR on the last beat
    step(1, 0, 'h1A2, 0, 1'b0);
    nop(1);
    step(2, 0, 0, 5, 1'b0);
    nop(1);
    step(2, 0, 0, 5, 1'b0);
    nop(7);
    step(3, 0, 0, 0, 1'b0);
    step(1, 1, 'h0F0F, 0, 1'b0);
    nop(10);

    // tRAS: PRE too early, then at exactly TRAS
    step(1, 2, 'h155, 0, 1'b0);
    nop(5);
    step(4, 2, 0, 0, 1'b0);
    nop(3);
    step(4, 2, 0, 0, 1'b0);
    nop(6);

    // halt over beat 3, with a command dropped while halted
    step(2, 0, 0, 2, 1'b0);
    nop(3);
    step(0, 0, 0, 0, 1'b1);
    step(1, 3, 'h77, 0, 1'b1);
    step(0, 0, 0, 0, 1'b1);
    nop(10);

    // REF blocked by active banks, PREA, REF at the tRP boundary, reset mid-refresh
    step(6, 0, 0, 0, 1'b0);
    step(5, 0, 0, 0, 1'b0);
    nop(3);
    step(6, 0, 0, 0, 1'b0);
    nop(8);
    reset = 1'b1;
    #1;
    check_cleared("reset_mid_refresh");
    model_reset();
    cmd = '0; halt = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      p = int'($urandom_range(0, 99));
      c = (p < 25) ? 0 : (p < 42) ? 1 : (p < 57) ? 2 : (p < 67) ? 3 :
          (p < 77) ? 4 : (p < 84) ? 5 : (p < 94) ? 6 : 7;
      step(c, int'($urandom_range(0, N - 1)), int'($urandom), int'($urandom),
           ($urandom_range(0, 9) == 0));
    end

    nop(30);
    vectors++;
    if (resp_q.size() != 0 || beat_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d responses and %0d beats outstanding, expected 0 and 0",
               resp_q.size(), beat_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
